cla_serial_addsub: RTL and testbench

- Multi-cycle add/subtract unit for the KGP-RISC ALU path.
- Inverse direction of the 4-bit CLA adder slice: it consumes one 4-bit carry-lookahead slice per clock.
- Primary operation is subtraction (a + ~b + 1); it also supports addition.
- Operands are latched on a start handshake. The result and the carry, zero, negative and overflow flags are produced after WIDTH/4 slice cycles, then done pulses for one cycle.

---
 rtl/cla_serial_addsub_pkg.sv | 15 +
 rtl/cla_serial_addsub_if.sv | 26 ++
 rtl/cla_serial_addsub_slice.sv | 28 ++
 rtl/cla_serial_addsub.sv | 130 +++++++++++++
 tb/tb_cla_serial_addsub.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cla_serial_addsub_pkg.sv
// rtl/cla_serial_addsub_pkg.sv - shared FSM encoding, slice width and ALU op codes
package cla_serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_serial_addsub_if.sv
// rtl/cla_serial_addsub_if.sv - request/result bundle between the ALU sequencer and the add/sub unit
interface cla_serial_addsub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, carry, zero, negative, overflow
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, carry, zero, negative, overflow
    );
endinterface

// File: rtl/cla_serial_addsub_slice.sv
// rtl/cla_serial_addsub_slice.sv - 4-bit augmented carry-lookahead slice with group P/G
module cla_serial_addsub_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       p_o,
    output logic       g_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Internal carries fully expanded so no ripple path exists inside the slice.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);

    assign sum_o = p ^ c;
    assign p_o   = &p;
    assign g_o   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/cla_serial_addsub.sv
// rtl/cla_serial_addsub.sv - nibble-serial add/subtract unit, one CLA slice per clock
module cla_serial_addsub
    import cla_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_serial_addsub_if.slave   bus
);
    localparam int NIB = WIDTH / SLICE_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if (WIDTH % SLICE_W != 0) begin : g_bad_width
        $error("cla_serial_addsub: WIDTH must be a multiple of 4");
    end

    state_e                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [NIB-1:0][SLICE_W-1:0]     a_q, a_d;
    logic [NIB-1:0][SLICE_W-1:0]     b_q, b_d;
    logic [NIB-1:0][SLICE_W-1:0]     res_q, res_d;
    logic                            cy_q, cy_d;
    logic                            carry_q, carry_d;
    logic                            zero_q, zero_d;
    logic                            neg_q, neg_d;
    logic                            ovf_q, ovf_d;

    logic [SLICE_W-1:0]              slice_sum;
    logic                            slice_p;
    logic                            slice_g;
    logic                            slice_cout;

    cla_serial_addsub_slice u_slice (
        .a_i   (a_q[cnt_q]),
        .b_i   (b_q[cnt_q]),
        .cin_i (cy_q),
        .sum_o (slice_sum),
        .p_o   (slice_p),
        .g_o   (slice_g)
    );

    assign slice_cout = slice_g | (slice_p & cy_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
                    a_d     = bus.a;
                    b_d     = (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
                    cy_d    = bus.op_sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                    neg_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[cnt_q] = slice_sum;
                cy_d         = slice_cout;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CW'(NIB - 1)) begin
                    // Flags come from the fully assembled next result, so they land with DONE.
                    cnt_d   = '0;
                    carry_d = slice_cout;
                    zero_d  = (res_d == '0);
                    neg_d   = res_d[NIB-1][SLICE_W-1];
                    ovf_d   = (a_q[NIB-1][SLICE_W-1] == b_q[NIB-1][SLICE_W-1])
                            & (res_d[NIB-1][SLICE_W-1] != a_q[NIB-1][SLICE_W-1]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = res_q;
    assign bus.carry    = carry_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_cla_serial_addsub.sv
// tb/tb_cla_serial_addsub.sv - randomized and directed bench for cla_serial_addsub against an arithmetic model
module tb_cla_serial_addsub;
    localparam int W   = 32;
    localparam int NIB = W / 4;

    logic clk = 1'b0;
    logic rst_n;

    cla_serial_addsub_if #(.WIDTH(W)) bus ();

    cla_serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle-accurate timing windows plus plain-arithmetic results.
    int          cyc    = 0;
    int          m_n0   = -100;
    int          m_free = 0;
    logic [31:0] m_res  = '0;
    logic [3:0]  m_flg  = '0;
    logic [31:0] v_res  = '0;
    logic [3:0]  v_flg  = '0;
    int          done_cnt = 0;

    function automatic void model_compute(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [32:0] wide;
        logic        c;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            m_res = a - b;
            c     = (a >= b);
            v     = ((sa - sb) != longint'($signed(m_res)));
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            m_res = wide[31:0];
            c     = wide[32];
            v     = ((sa + sb) != longint'($signed(m_res)));
        end
        m_flg = {c, (m_res == 32'd0), m_res[31], v};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_n0   = -100;
            m_free = 0;
            v_res  = '0;
            v_flg  = '0;
        end else begin
            cyc++;
            if (bus.start && cyc >= m_free) begin
                m_n0   = cyc;
                m_free = cyc + NIB + 2;
                model_compute(bus.op_sub, bus.a, bus.b);
                v_res  = '0;
                v_flg  = '0;
            end else if (cyc == m_n0 + NIB) begin
                v_res = m_res;
                v_flg = m_flg;
            end
        end
    end

    initial forever begin
        bit eb;
        bit ed;
        @(negedge clk);
        eb = (cyc >= m_n0) && (cyc < m_n0 + NIB);
        ed = (cyc == m_n0 + NIB);
        if (bus.done) done_cnt++;
        chk("busy", {31'd0, bus.busy}, {31'd0, eb});
        chk("done", {31'd0, bus.done}, {31'd0, ed});
        if (!eb) begin
            chk("result", bus.result, v_res);
            chk("flags", {28'd0, bus.carry, bus.zero, bus.negative, bus.overflow}, {28'd0, v_flg});
        end else begin
            chk("flags_run", {28'd0, bus.carry, bus.zero, bus.negative, bus.overflow}, 32'd0);
        end
    end

    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef, input string nm);
        int lat;
        bit seen;
        bus.start  = 1'b1;
        bus.op_sub = op;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk); #2;
        bus.start  = 1'b0;
        bus.a      = $urandom;
        bus.b      = $urandom;
        bus.op_sub = 1'($urandom);
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                lat  = i;
            end
        end
        chk({nm, "_latency"}, lat, 32'd9);
        chk({nm, "_result"}, bus.result, er);
        chk({nm, "_flags"}, {28'd0, bus.carry, bus.zero, bus.negative, bus.overflow}, {28'd0, ef});
        @(posedge clk); #2;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dc0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // flags literal order: {carry, zero, negative, overflow}
        do_op(1'b1, 32'd5, 32'd3, 32'h0000_0002, 4'b1000, "sub_5_3");
        do_op(1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0010, "sub_3_5");
        do_op(1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b1001, "sub_ovf");
        do_op(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0, 4'b1100, "sub_eq");
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 4'b1100, "add_wrap");
        do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0011, "add_ovf");

        dc0 = done_cnt;
        bus.start = 1'b1; bus.op_sub = 1'b1; bus.a = 32'd100; bus.b = 32'd1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("busy_ignore_done_count", done_cnt - dc0, 32'd1);
        chk("busy_ignore_result", bus.result, 32'd99);

        dc0 = done_cnt;
        bus.start = 1'b1; bus.op_sub = 1'b1; bus.a = 32'hF0; bus.b = 32'h0F;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_flags", {28'd0, bus.carry, bus.zero, bus.negative, bus.overflow}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("abort_no_done", done_cnt - dc0, 32'd0);
        do_op(1'b1, 32'hF0, 32'h0F, 32'h0000_00E1, 4'b1000, "after_abort");

        for (int n = 0; n < 60; n++) begin
            int hold;
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                bus.start  = 1'b1;
                bus.op_sub = 1'($urandom);
                bus.a      = pick();
                bus.b      = pick();
                @(posedge clk); #2;
            end
            bus.start = 1'b0;
            bus.a     = $urandom;
            bus.b     = $urandom;
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #2;
        end
        repeat (12) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
